// File: rtl/cgra_arb_pkg.sv
// Shared definitions for the CGRA kernel-launch arbiter.
//   arb_state_t        : arbiter FSM state encoding
//   CGRA_ARB_N_SLOTS   : default number of requesting cores
//   CGRA_ARB_KER_ID_W  : default kernel ID width (ID 0 = "no kernel")
package cgra_arb_pkg;

    localparam int unsigned CGRA_ARB_N_SLOTS  = 4;
    localparam int unsigned CGRA_ARB_KER_ID_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

endpackage : cgra_arb_pkg

// File: rtl/cgra_kernel_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Rotates the eligible vector so that rr_ptr_i lands on bit 0, takes the
// lowest set bit, then adds rr_ptr_i back to get the absolute slot index.
//   eligible_i   in  N_SLOTS  slots that may be granted this cycle
//   rr_ptr_i     in  SLOT_W   first slot to consider
//   grant_idx_o  out SLOT_W   selected slot (valid only with grant_vld_o)
//   grant_vld_o  out 1        at least one slot is eligible
module rr_pick #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned SLOT_W  = $clog2(N_SLOTS)
) (
    input  logic [N_SLOTS-1:0] eligible_i,
    input  logic [SLOT_W-1:0]  rr_ptr_i,
    output logic [SLOT_W-1:0]  grant_idx_o,
    output logic               grant_vld_o
);

    logic [N_SLOTS-1:0] rotated;
    logic [SLOT_W-1:0]  rot_idx;
    logic [SLOT_W-1:0]  src_idx;

    always_comb begin
        rotated = '0;
        src_idx = '0;
        // N_SLOTS is a power of two, so SLOT_W-bit addition wraps mod N_SLOTS.
        for (int i = 0; i < N_SLOTS; i++) begin
            src_idx    = SLOT_W'(i) + rr_ptr_i;
            rotated[i] = eligible_i[src_idx];
        end
    end

    always_comb begin
        rot_idx     = '0;
        grant_vld_o = 1'b0;
        // Scan downward so the lowest set bit is the one left standing.
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                rot_idx     = SLOT_W'(i);
                grant_vld_o = 1'b1;
            end
        end
    end

    assign grant_idx_o = rot_idx + rr_ptr_i;

endmodule : rr_pick

// File: rtl/cgra_kernel_arbiter.sv
// cgra_kernel_arbiter: round-robin scheduler sharing the CGRA kernel-launch
// path among N_SLOTS cores. One outstanding kernel per slot; a slot is freed
// by its done_i event.
//
// Optional feature: define CGRA_ARB_WDOG_EN to add a per-slot watchdog that
// frees a slot whose completion never arrives and pulses timeout_o.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_valid_i       per-slot kernel request
//   req_ker_id_i      per-slot kernel ID, slot s at [s*KER_ID_W +: KER_ID_W]
//   req_ready_o       one-hot single-cycle capture pulse to the chosen slot
//   done_i            per-slot completion event
//   out_valid_o       downstream launch request
//   out_ready_i       downstream accept
//   out_ker_id_o      kernel ID of the launch
//   out_slot_o        originating slot of the launch
//   busy_o            slot has an outstanding kernel
//   timeout_o         watchdog expiry pulse (constant 0 without the feature)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | searching for an eligible slot; capture happens here
// ARB_OFFER | {slot, kernel ID} held on the output until out_ready_i
module cgra_kernel_arbiter
    import cgra_arb_pkg::*;
#(
    parameter int unsigned N_SLOTS  = CGRA_ARB_N_SLOTS,
    parameter int unsigned KER_ID_W = CGRA_ARB_KER_ID_W,
    parameter int unsigned SLOT_W   = $clog2(N_SLOTS),
    parameter int unsigned WDOG_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_SLOTS-1:0]          req_valid_i,
    input  logic [N_SLOTS*KER_ID_W-1:0] req_ker_id_i,
    output logic [N_SLOTS-1:0]          req_ready_o,
    input  logic [N_SLOTS-1:0]          done_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [KER_ID_W-1:0]         out_ker_id_o,
    output logic [SLOT_W-1:0]           out_slot_o,
    output logic [N_SLOTS-1:0]          busy_o,
    output logic [N_SLOTS-1:0]          timeout_o
);

    if (((1 << SLOT_W) != N_SLOTS) || (N_SLOTS < 2) || (WDOG_W < 2)) begin : g_param_check
        $error("cgra_kernel_arbiter: N_SLOTS must be a power of two >= 2 and WDOG_W >= 2");
    end

    arb_state_t          state_q, state_d;
    logic [SLOT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_SLOTS-1:0]  busy_q, busy_d;
    logic [KER_ID_W-1:0] ker_id_q, ker_id_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;

    logic [KER_ID_W-1:0] req_ker_id [N_SLOTS];
    logic [N_SLOTS-1:0]  eligible;
    logic [N_SLOTS-1:0]  set_mask;
    logic [N_SLOTS-1:0]  timeout;
    logic [SLOT_W-1:0]   grant_idx;
    logic                grant_vld;

    always_comb begin
        for (int s = 0; s < N_SLOTS; s++) begin
            req_ker_id[s] = req_ker_id_i[s*KER_ID_W +: KER_ID_W];
            // Busy is the registered value, so a done_i arriving this cycle
            // only makes the slot eligible from the next cycle on.
            eligible[s]   = req_valid_i[s] & ~busy_q[s] & (req_ker_id[s] != '0);
        end
    end

    rr_pick #(
        .N_SLOTS (N_SLOTS),
        .SLOT_W  (SLOT_W)
    ) u_rr_pick (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        ker_id_d    = ker_id_q;
        slot_d      = slot_q;
        req_ready_o = '0;
        set_mask    = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_vld) begin
                    req_ready_o[grant_idx] = 1'b1;
                    ker_id_d               = req_ker_id[grant_idx];
                    slot_d                 = grant_idx;
                    state_d                = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                if (out_ready_i) begin
                    set_mask[slot_q] = 1'b1;
                    rr_ptr_d         = slot_q + 1'b1;
                    state_d          = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // A new launch on a slot overrides a same-cycle clear of that slot.
    assign busy_d = (busy_q & ~done_i & ~timeout) | set_mask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            busy_q   <= '0;
            ker_id_q <= '0;
            slot_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            ker_id_q <= ker_id_d;
            slot_q   <= slot_d;
        end
    end

`ifdef CGRA_ARB_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q [N_SLOTS];
    logic [WDOG_W-1:0] wdog_cnt_d [N_SLOTS];

    always_comb begin
        for (int s = 0; s < N_SLOTS; s++) begin
            timeout[s] = busy_q[s] & (wdog_cnt_q[s] == '1);
            if (!busy_q[s] || done_i[s] || set_mask[s] || timeout[s]) begin
                wdog_cnt_d[s] = '0;
            end else begin
                wdog_cnt_d[s] = wdog_cnt_q[s] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                wdog_cnt_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                wdog_cnt_q[s] <= wdog_cnt_d[s];
            end
        end
    end
`else
    assign timeout = '0;
`endif

    assign timeout_o    = timeout;
    assign busy_o       = busy_q;
    assign out_valid_o  = (state_q == ARB_OFFER);
    assign out_ker_id_o = ker_id_q;
    assign out_slot_o   = slot_q;

endmodule : cgra_kernel_arbiter

// File: tb/tb_cgra_kernel_arbiter.sv
// Directed bench for cgra_kernel_arbiter (N_SLOTS=4, KER_ID_W=4).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_cgra_kernel_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [15:0] req_ker_id_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  done_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  out_ker_id_o;
    logic [1:0]  out_slot_o;
    logic [3:0]  busy_o;
    logic [3:0]  timeout_o;

    int n_cmp  = 0;
    int n_fail = 0;

    cgra_kernel_arbiter #(
        .N_SLOTS  (4),
        .KER_ID_W (4),
        .SLOT_W   (2),
        .WDOG_W   (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ker_id_i (req_ker_id_i),
        .req_ready_o  (req_ready_o),
        .done_i       (done_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_ker_id_o (out_ker_id_o),
        .out_slot_o   (out_slot_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] rv, input logic [3:0] dn, input logic ordy);
        @(negedge clk_i);
        req_valid_i = rv;
        done_i      = dn;
        out_ready_i = ordy;
        #1;
    endtask

    task automatic chk_offer(input string tag, input logic [1:0] slot, input logic [3:0] id);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, "_slot"}, 32'(out_slot_o), 32'(slot));
        chk({tag, "_id"}, 32'(out_ker_id_o), 32'(id));
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = '0;
        req_ker_id_i = '0;
        done_i       = '0;
        out_ready_i  = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_slot", 32'(out_slot_o), 32'd0);
        chk("rst_id", 32'(out_ker_id_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single launch: slot 2, ID 5
        req_ker_id_i = {4'd0, 4'd5, 4'd0, 4'd0};
        cyc(4'b0100, 4'b0000, 1'b0);
        chk("t1_ready", 32'(req_ready_o), 32'b0100);
        chk("t1_novalid", 32'(out_valid_o), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk_offer("t1_offer", 2'd2, 4'd5);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("t1_hold", 32'(out_valid_o), 32'd1);
        cyc(4'b0000, 4'b0100, 1'b0);
        chk("t1_busy", 32'(busy_o), 32'b0100);
        chk("t1_idle", 32'(out_valid_o), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("t1_freed", 32'(busy_o), 32'd0);

        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;

        // Round robin over slots 0,1,3 with continuous requests
        req_ker_id_i = {4'd3, 4'd0, 4'd2, 4'd1};
        cyc(4'b1011, 4'b0000, 1'b1);
        chk("t2_g0", 32'(req_ready_o), 32'b0001);
        cyc(4'b1011, 4'b0000, 1'b1);
        chk_offer("t2_o0", 2'd0, 4'd1);
        cyc(4'b1011, 4'b0000, 1'b1);
        chk("t2_b0", 32'(busy_o), 32'b0001);
        chk("t2_g1", 32'(req_ready_o), 32'b0010);
        cyc(4'b1011, 4'b0000, 1'b1);
        chk_offer("t2_o1", 2'd1, 4'd2);
        cyc(4'b1011, 4'b0000, 1'b1);
        chk("t2_b1", 32'(busy_o), 32'b0011);
        chk("t2_g3", 32'(req_ready_o), 32'b1000);
        cyc(4'b1011, 4'b0000, 1'b1);
        chk_offer("t2_o3", 2'd3, 4'd3);
        cyc(4'b1011, 4'b0001, 1'b1);
        chk("t2_b3", 32'(busy_o), 32'b1011);
        chk("t2_allbusy", 32'(req_ready_o), 32'd0);
        chk("t2_allbusy_v", 32'(out_valid_o), 32'd0);
        cyc(4'b1011, 4'b0000, 1'b1);
        chk("t2_done0", 32'(busy_o), 32'b1010);
        chk("t2_wrap", 32'(req_ready_o), 32'b0001);
        cyc(4'b1011, 4'b0000, 1'b1);
        chk_offer("t2_o0b", 2'd0, 4'd1);
        cyc(4'b0000, 4'b1011, 1'b0);
        chk("t2_b_end", 32'(busy_o), 32'b1011);

        // Back-pressure: out_ready_i low for 10 cycles (rr_ptr = 1)
        req_ker_id_i = {4'd0, 4'd0, 4'd9, 4'd4};
        cyc(4'b0011, 4'b0000, 1'b0);
        chk("t3_clear", 32'(busy_o), 32'd0);
        chk("t3_g1", 32'(req_ready_o), 32'b0010);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0001, 4'b0000, 1'b0);
            chk_offer($sformatf("t3_stall%0d", i), 2'd1, 4'd9);
        end
        cyc(4'b0001, 4'b0000, 1'b1);
        chk("t3_acc_v", 32'(out_valid_o), 32'd1);
        cyc(4'b0001, 4'b0000, 1'b1);
        chk("t3_b1", 32'(busy_o), 32'b0010);
        chk("t3_g0", 32'(req_ready_o), 32'b0001);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk_offer("t3_o0", 2'd0, 4'd4);

        // done_i[1] in the same cycle slot 1 requests again
        req_ker_id_i = {4'd0, 4'd0, 4'd7, 4'd0};
        cyc(4'b0010, 4'b0010, 1'b0);
        chk("t4_busy", 32'(busy_o), 32'b0011);
        chk("t4_nogrant", 32'(req_ready_o), 32'd0);
        cyc(4'b0010, 4'b0000, 1'b0);
        chk("t4_freed", 32'(busy_o), 32'b0001);
        chk("t4_g1", 32'(req_ready_o), 32'b0010);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk_offer("t4_o1", 2'd1, 4'd7);
        cyc(4'b0000, 4'b0011, 1'b0);
        chk("t4_b", 32'(busy_o), 32'b0011);

        // ID 0 on slot 0 is never accepted (rr_ptr = 2)
        req_ker_id_i = {4'd0, 4'd0, 4'd3, 4'd0};
        cyc(4'b0011, 4'b0000, 1'b0);
        chk("t5_clear", 32'(busy_o), 32'd0);
        chk("t5_g1", 32'(req_ready_o), 32'b0010);
        cyc(4'b0001, 4'b0000, 1'b1);
        chk_offer("t5_o1", 2'd1, 4'd3);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("t5_b", 32'(busy_o), 32'b0010);
        chk("t5_id0_a", 32'(req_ready_o), 32'd0);
        chk("t5_idle", 32'(out_valid_o), 32'd0);
        cyc(4'b0001, 4'b0000, 1'b0);
        chk("t5_id0_b", 32'(req_ready_o), 32'd0);

        // Handshake on slot 2 with same-cycle done_i[2]: set wins
        req_ker_id_i = {4'd0, 4'd5, 4'd0, 4'd0};
        cyc(4'b0100, 4'b0000, 1'b0);
        chk("t6_g2", 32'(req_ready_o), 32'b0100);
        cyc(4'b0000, 4'b0100, 1'b1);
        chk_offer("t6_o2", 2'd2, 4'd5);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk("t6_setwins", 32'(busy_o), 32'b0110);
        chk("t6_timeout", 32'(timeout_o), 32'd0);

        // Reset during OFFER drops the launch and rewinds rr_ptr (rr_ptr = 3)
        req_ker_id_i = {4'd6, 4'd0, 4'd0, 4'd0};
        cyc(4'b1000, 4'b0000, 1'b0);
        chk("t7_g3", 32'(req_ready_o), 32'b1000);
        cyc(4'b0000, 4'b0000, 1'b0);
        chk_offer("t7_o3", 2'd3, 4'd6);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("t7_rst_v", 32'(out_valid_o), 32'd0);
        chk("t7_rst_busy", 32'(busy_o), 32'd0);
        chk("t7_rst_slot", 32'(out_slot_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        req_ker_id_i = {4'd6, 4'd0, 4'd0, 4'd1};
        cyc(4'b1001, 4'b0000, 1'b0);
        chk("t7_ptr0", 32'(req_ready_o), 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_cgra_kernel_arbiter

// File: doc/cgra_kernel_arbiter.md
Name: cgra_kernel_arbiter

Overview:
- Round-robin scheduler that shares the CGRA kernel-launch path among N_SLOTS requesting cores.
- Each core presents a kernel ID with valid/ready. The arbiter selects one eligible slot, then offers {slot, kernel ID} downstream to the column-mapping synchronizer over a valid/ready handshake.
- Tracks one outstanding kernel per slot and frees the slot on that slot's completion event.

Parameters:
- N_SLOTS, 4, number of requesting cores/slots (power of two, >=2).
- KER_ID_W, 4, kernel ID width; ID 0 means "no kernel".
- SLOT_W, $clog2(N_SLOTS), slot index width (derived).
- WDOG_W, 16, watchdog counter width (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  N_SLOTS  per-slot kernel request.
- req_ker_id_i  in  N_SLOTS*KER_ID_W  per-slot kernel ID; slot s occupies bits [s*KER_ID_W +: KER_ID_W].
- req_ready_o  out  N_SLOTS  one-hot, single-cycle capture pulse to the selected slot.
- done_i  in  N_SLOTS  per-slot completion event (evt from the synchronizer).
- out_valid_o  out  1  downstream launch request.
- out_ready_i  in  1  downstream accept.
- out_ker_id_o  out  KER_ID_W  kernel ID of the launch.
- out_slot_o  out  SLOT_W  originating slot.
- busy_o  out  N_SLOTS  slot has an outstanding kernel.
- timeout_o  out  N_SLOTS  watchdog expiry pulse; tied 0 without the macro.

Behaviour:
- Reset (async, rst_i=1): state=ARB_IDLE, rr_ptr=0, busy_o=0, out_valid_o=0, out_ker_id_o=0, out_slot_o=0, req_ready_o=0, timeout_o=0.
- Eligibility: eligible[s] = req_valid_i[s] & ~busy_o[s] & (ker_id[s]!=0). A nonzero-valid request with ID 0 is never accepted and stays pending.
- FSM, two states:
  - ARB_IDLE: if any slot is eligible, pick the first eligible slot searching from rr_ptr upward, wrapping mod N_SLOTS. Same cycle: req_ready_o[sel]=1 (combinational), ker_id and slot captured into the output regs. Next state is ARB_OFFER. Otherwise stay in ARB_IDLE.
  - ARB_OFFER: out_valid_o=1; out_ker_id_o and out_slot_o held stable. When out_ready_i=1: busy_o[slot] set, rr_ptr = slot+1 (wraps to 0 after N_SLOTS-1), return to ARB_IDLE. No new capture happens in this cycle.
- Latency: request seen in IDLE cycle t gives out_valid_o at t+1. Minimum spacing between launches is 2 cycles.
- out_valid_o never drops without out_ready_i (AXI-style stability).
- done_i[s]=1 clears busy_o[s] at the next edge. done_i on a non-busy slot is ignored.
- Simultaneous done_i[s] and an IDLE request from slot s: the slot is not eligible this cycle (busy is still 1) and becomes eligible the following cycle.
- Simultaneous done_i[s] and handshake completion for slot s: set wins (a new kernel is outstanding). This case is only legal if s was not busy.
- Any number of slots may be busy at once; with all slots busy the FSM idles.
- Reset mid-OFFER drops the pending launch; requesters must re-request.

Optional Feature:
- Macro CGRA_ARB_WDOG_EN.
- Defined: a per-slot WDOG_W-bit counter runs while busy_o[s]=1 and clears on done_i[s] or when the slot is granted. On reaching all-ones: pulse timeout_o[s] for 1 cycle, clear busy_o[s], reset the counter.
- Undefined: no counters; timeout_o is constant 0; busy clears only on done_i.

Decomposition:
- Shared package cgra_arb_pkg: arb_state_t enum (ARB_IDLE, ARB_OFFER), CGRA_ARB_N_SLOTS, CGRA_ARB_KER_ID_W.
- Sub-module rr_pick: combinational rotate, priority-encode, unrotate. Inputs eligible and rr_ptr; outputs grant index and grant-valid.

Test Plan:
- Reset then slot 2 requests ID 5 -> req_ready_o=4'b0100 in cycle 1; out_valid_o=1, out_slot_o=2, out_ker_id_o=5 in cycle 2; out_ready_i=1 -> busy_o=4'b0100.
- Slots 0,1,3 request continuously, out_ready_i always 1 -> grants in order 0,1,3 (then 0 once done_i frees it); rr_ptr wraps 3->0.
- out_ready_i held 0 for 10 cycles during OFFER -> out_valid_o, out_slot_o and out_ker_id_o stable for all 10; no req_ready_o pulses.
- Slot 1 busy, requests ID 7 while done_i[1] pulses -> no grant that cycle; granted the next IDLE cycle.
- Slot 0 requests ID 0 alongside slot 1 with ID 3 -> only slot 1 granted; slot 0 never sees req_ready_o.
- With CGRA_ARB_WDOG_EN and WDOG_W=4: slot 3 granted, no done_i -> timeout_o[3] pulses after 15 busy cycles; busy_o[3] clears.
